// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter that drives the one-hot SEL of a 4:1 mux. Grants last until REQ drops, followed by a one-cycle gap.
// Optional grant timeout is compiled in with `define ARB_TIMEOUT_EN (limit set by MAX_GRANT).
module mux_arbiter_rr #(
    parameter logic [7:0] MAX_GRANT = 8'd16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] SEL,
    output logic [1:0] GRANT_IDX,
    output logic       BUSY,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] win_idx, cand, idx_nxt;
    logic [3:0] sel_nxt;
    logic       win_vld, busy_nxt, hold, expire;

    if (MAX_GRANT == 8'd0) begin : g_bad_max_grant
        $error("MAX_GRANT must be in 1..255");
    end

    assign hold = REQ[GRANT_IDX];

    // Search order ptr, ptr+1, ptr+2, ptr+3; descending loop so the nearest hit wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        cand    = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (REQ[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] grant_cnt;
    logic       timeout_q;

    assign expire = (state == GRANT) && hold && (grant_cnt == MAX_GRANT - 8'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_cnt <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            grant_cnt <= (state == GRANT) ? grant_cnt + 8'd1 : 8'd0;
            timeout_q <= expire;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign expire  = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = SEL;
        idx_nxt   = GRANT_IDX;
        busy_nxt  = BUSY;
        ptr_nxt   = ptr;
        case (state)
            IDLE, GAP: begin
                if (win_vld) begin
                    state_nxt = GRANT;
                    sel_nxt   = 4'b0001 << win_idx;
                    idx_nxt   = win_idx;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    sel_nxt   = 4'b0000;
                    idx_nxt   = 2'd0;
                    busy_nxt  = 1'b0;
                end
            end
            GRANT: begin
                // Winner stays latched; only its own REQ (or the timeout) ends the grant.
                if (!hold || expire) begin
                    state_nxt = GAP;
                    sel_nxt   = 4'b0000;
                    idx_nxt   = 2'd0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = GRANT_IDX + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 4'b0000;
                idx_nxt   = 2'd0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            SEL       <= 4'b0000;
            GRANT_IDX <= 2'd0;
            BUSY      <= 1'b0;
            ptr       <= 2'd0;
        end else begin
            state     <= state_nxt;
            SEL       <= sel_nxt;
            GRANT_IDX <= idx_nxt;
            BUSY      <= busy_nxt;
            ptr       <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed bench for mux_arbiter_rr: table of per-cycle vectors plus hand sequences for pulses, async reset and timeout.
module tb_mux_arbiter_rr;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] SEL;
    logic [1:0] GRANT_IDX;
    logic       BUSY;
    logic       TIMEOUT;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    logic [7:0] din [4];
    logic [7:0] mux_out;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    mux_arbiter_rr #(.MAX_GRANT(8'd4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .SEL       (SEL),
        .GRANT_IDX (GRANT_IDX),
        .BUSY      (BUSY),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // 4:1 one-hot mux fed by the arbiter's SEL.
    always_comb begin
        mux_out = 8'h00;
        for (int i = 0; i < 4; i++)
            if (SEL[i]) mux_out = mux_out | din[i];
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            total++;
            if (!$onehot0(SEL) || ((SEL != 4'b0000) != BUSY) ||
                (mux_out != (BUSY ? din[GRANT_IDX] : 8'h00)))
                begin
                bad++;
                $display("FAIL monitor t=%0t: sel=%b busy=%b idx=%0d mux=%h, want one-hot0 sel and mux=selected input or 0",
                         $time, SEL, BUSY, GRANT_IDX, mux_out);
            end
        end
    end

    function automatic void add(logic r, logic [3:0] q, logic [3:0] s, logic [1:0] ix, logic b, logic t);
        vec_t v;
        v.rst = r; v.req = q; v.sel = s; v.idx = ix; v.busy = b; v.tmo = t;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [3:0] es, logic [1:0] ei, logic eb, logic et);
        logic [7:0] em;
        em = eb ? din[ei] : 8'h00;
        total++;
        if ({SEL, GRANT_IDX, BUSY, TIMEOUT, mux_out} !== {es, ei, eb, et, em}) begin
            bad++;
            $display("FAIL %s t=%0t: got sel=%b idx=%0d busy=%b tmo=%b mux=%h, want sel=%b idx=%0d busy=%b tmo=%b mux=%h",
                     name, $time, SEL, GRANT_IDX, BUSY, TIMEOUT, mux_out, es, ei, eb, et, em);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        din[0] = 8'hA1; din[1] = 8'hB2; din[2] = 8'hC4; din[3] = 8'hD8;

        // Single requester 2 for 5 sampled cycles, then idle; leaves ptr=3.
        for (int i = 0; i < 4; i++) add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
`ifdef ARB_TIMEOUT_EN
        add(0, 4'b0100, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
`else
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
`endif
        // ptr=3: 0011 wraps to requester 0; then requester 1 after the gap.
        add(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0010, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // ptr=2: 0011 searches 2,3,0 -> requester 0.
        add(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Reset with requests pending, then all four requesting in rotation.
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1110, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1010, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1101, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1011, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b0111, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);

        RST = 1'b1;
        REQ = 4'b1111;
        step();
        check("reset", 4'b0000, 2'd0, 0, 0);
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            RST = vecs[i].rst;
            REQ = vecs[i].req;
            step();
            check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].idx, vecs[i].busy, vecs[i].tmo);
        end
        RST = 1'b0;

        // Request pulse that vanishes before the edge is never granted.
        REQ = 4'b0100;
        #4;
        REQ = 4'b0000;
        @(posedge CLK);
        #1;
        check("pulse_ignored", 4'b0000, 2'd0, 0, 0);
        step();
        check("pulse_no_memory", 4'b0000, 2'd0, 0, 0);

        // Asynchronous reset while requester 3 owns the mux.
        REQ = 4'b1000;
        step();
        check("grant3", 4'b1000, 2'd3, 1, 0);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst", 4'b0000, 2'd0, 0, 0);
        REQ = 4'b1001;
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("post_rst_prio0", 4'b0001, 2'd0, 1, 0);
        REQ = 4'b0000;
        step();
        step();

        // Long grant with another requester waiting.
        RST = 1'b1;
        step();
        RST = 1'b0;
        REQ = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin step(); check("tmo_g0", 4'b0001, 2'd0, 1, 0); end
        step(); check("tmo_gap0", 4'b0000, 2'd0, 0, 1);
        for (int k = 0; k < 4; k++) begin step(); check("tmo_g1", 4'b0010, 2'd1, 1, 0); end
        step(); check("tmo_gap1", 4'b0000, 2'd0, 0, 1);
        step(); check("tmo_wrap0", 4'b0001, 2'd0, 1, 0);
        for (int k = 0; k < 3; k++) begin step(); check("tmo_edge_g0", 4'b0001, 2'd0, 1, 0); end
        REQ = 4'b0000;
        step(); check("release_on_limit", 4'b0000, 2'd0, 0, 0);
        REQ = 4'b0001;
        for (int k = 0; k < 4; k++) begin step(); check("solo_g0", 4'b0001, 2'd0, 1, 0); end
        step(); check("solo_gap", 4'b0000, 2'd0, 0, 1);
        step(); check("solo_regrant", 4'b0001, 2'd0, 1, 0);
`else
        for (int k = 0; k < 10; k++) begin step(); check("no_tmo_hold", 4'b0001, 2'd0, 1, 0); end
`endif
        REQ = 4'b0000;
        step();
        check("final_gap", 4'b0000, 2'd0, 0, 0);
        step();
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
